sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
- Serial-in/parallel-out frame receiver that sits directly upstream of the 7-bit parallel holding register.
- Collects a start-triggered serial frame, one bit per bit strobe, LSB first, and checks a stop bit.
- Presents the assembled word on dout with a one-cycle valid pulse, so the downstream register can load it on that pulse.

Parameters:
- WIDTH, 7, number of data bits per frame (the downstream register width); legal range 2..16.
- MSB_FIRST, 0, 0 = first received data bit lands in dout[0]; 1 = first received data bit lands in dout[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous active-low reset; res=0 resets the block immediately.
- start  input  1  frame-start pulse; honoured only in IDLE.
- bit_en  input  1  bit strobe; sin is sampled on edges where bit_en=1.
- sin  input  1  serial data.
- dout  output  WIDTH  last successfully received word; held between frames.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- busy  output  1  high from the accepted start until the frame ends.
- frame_err  output  1  one-cycle pulse when the stop bit is 0.

Behaviour:
- Reset (res=0, asynchronous assertion): state=IDLE, bit counter=0, shift register=0, dout=0, dout_valid=0, busy=0, frame_err=0.
- All outputs are registered.
- States:
  - IDLE: start=1 -> DATA with counter=0, busy=1. bit_en in the start cycle is ignored; the first data bit is taken at the next bit_en.
  - DATA: each edge with bit_en=1 shifts sin in and increments the counter. When the counter reaches WIDTH -> STOP (or PARITY when the optional feature is enabled). bit_en=0 holds all state, and gaps of any length are allowed.
  - STOP: on the next edge with bit_en=1, sample the stop bit.
    - stop bit = 1: dout <= shift register, dout_valid=1 for that single cycle.
    - stop bit = 0: frame_err=1 for one cycle, dout unchanged.
    - Either way -> IDLE with busy=0 in the same cycle.
- Latency: dout and dout_valid change on the clock edge that samples the stop bit.
- start in DATA or STOP is ignored and does not restart the frame.
- start in the cycle busy falls is accepted only if state is already IDLE, i.e. one cycle later; back-to-back frames need one idle cycle.
- dout_valid and frame_err are never high together.
- Reset mid-frame aborts the frame, clears dout to 0, and emits no pulse.
- Counter width is clog2(WIDTH+1); no wrap is possible because the counter stops at WIDTH.
- X on sin while bit_en=0 must not affect state.

Optional Feature:
- Macro: SIPO_FRAME_RX_PARITY_EN.
- Defined:
  - Adds output parity_err (1 bit, reset 0) and state PARITY between DATA and STOP.
  - PARITY samples one bit at bit_en and requires even parity over the data bits plus the parity bit.
  - On mismatch, the frame still proceeds through STOP, but the STOP edge pulses parity_err instead of dout_valid and leaves dout unchanged.
  - If the stop bit is also 0, both parity_err and frame_err pulse.
- Undefined: no PARITY state and no parity_err port; the frame is start, WIDTH data bits, stop.

Test Plan:
- Reset check: res=0 with random sin/start/bit_en -> dout=7'b0000000, dout_valid=0, busy=0, frame_err=0 throughout.
- Nominal frame: start, then bit_en bits 1,1,1,0,0,0,0, then stop=1 -> dout=7'b0000111, dout_valid high exactly one cycle on the stop edge, busy high from the cycle after start through the stop edge.
- Stop error: frame 1,0,1,0,1,0,1 with stop=0 -> frame_err one-cycle pulse, dout stays 7'b0000111, no dout_valid.
- Gapped strobes: frame 1,0,1,0,1,0,1 with 0-3 idle cycles between bit_en pulses and a spurious start mid-frame, stop=1 -> dout=7'b1010101, one dout_valid.
- Reset mid-frame: assert res=0 after 3 data bits -> immediate dout=0, busy=0. Then a full frame of 1,1,0,0,1,1,0 with stop=1 -> dout=7'b0110011.
- Parity (SIPO_FRAME_RX_PARITY_EN): data 1,1,1,0,0,0,0, parity 1, stop 1 -> dout=7'b0000111, dout_valid. Same data with parity 0 -> parity_err pulse, dout unchanged.

Source files
------------

// File: rtl/sipo_frame_rx_if.sv
// sipo_frame_rx_if
//   Bundles the serial input side and the parallel result side of the
//   frame receiver. Clock and reset stay as plain ports on the modules.
//
//   Signals:
//     start       frame-start pulse           (master -> slave)
//     bit_en      bit strobe                  (master -> slave)
//     sin         serial data                 (master -> slave)
//     dout        last good word, WIDTH bits  (slave -> master)
//     dout_valid  one-cycle update pulse      (slave -> master)
//     busy        frame in progress           (slave -> master)
//     frame_err   one-cycle bad-stop pulse    (slave -> master)
//     parity_err  one-cycle parity pulse, only with SIPO_FRAME_RX_PARITY_EN
//
//   Optional feature macro: SIPO_FRAME_RX_PARITY_EN
interface sipo_frame_rx_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic             bit_en;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_err;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic             parity_err;
`endif

`ifdef SIPO_FRAME_RX_PARITY_EN
  modport master (
    output start, bit_en, sin,
    input  dout, dout_valid, busy, frame_err, parity_err
  );
  modport slave (
    input  start, bit_en, sin,
    output dout, dout_valid, busy, frame_err, parity_err
  );
`else
  modport master (
    output start, bit_en, sin,
    input  dout, dout_valid, busy, frame_err
  );
  modport slave (
    input  start, bit_en, sin,
    output dout, dout_valid, busy, frame_err
  );
`endif
endinterface

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
//   Serial-in/parallel-out frame receiver. After an accepted start it
//   collects WIDTH data bits, one per bit strobe, then samples a stop bit.
//   A good stop bit loads dout and pulses dout_valid for one cycle; a bad
//   stop bit pulses frame_err and leaves dout untouched. All outputs are
//   registered.
//
//   Ports:
//     clk   rising-edge clock
//     res   asynchronous active-low reset
//     bus   sipo_frame_rx_if.slave (start, bit_en, sin in;
//           dout, dout_valid, busy, frame_err [, parity_err] out)
//
//   Parameters:
//     WIDTH      data bits per frame (2..16)
//     MSB_FIRST  0: first data bit lands in dout[0]; 1: in dout[WIDTH-1]
//
//   Optional feature macro: SIPO_FRAME_RX_PARITY_EN
//     Adds a PARITY state after the data bits (even parity over data plus
//     parity bit) and the parity_err output.
module sipo_frame_rx #(
  parameter int WIDTH     = 7,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            res,
  sipo_frame_rx_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             valid_q, valid_nxt;
  logic             busy_q, busy_nxt;
  logic             ferr_q, ferr_nxt;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic             perr_q, perr_nxt;
  logic             pbad, pbad_nxt;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic b);
    if (MSB_FIRST)
      return {sr[WIDTH-2:0], b};
    else
      return {b, sr[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    dout_nxt  = dout_q;
    valid_nxt = 1'b0;
    busy_nxt  = busy_q;
    ferr_nxt  = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    perr_nxt  = 1'b0;
    pbad_nxt  = pbad;
`endif
    // sin is only looked at under bit_en, so X on an unstrobed cycle
    // cannot reach any state.
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
          pbad_nxt  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bus.bit_en) begin
          shreg_nxt = shift_in(shreg, bus.sin);
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef SIPO_FRAME_RX_PARITY_EN
        if (bus.bit_en) begin
          // Even parity: data bits XOR parity bit must be 0.
          pbad_nxt  = (^shreg) ^ bus.sin;
          state_nxt = STOP;
        end
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (bus.bit_en) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
          perr_nxt  = pbad;
          if (bus.sin && !pbad) begin
            dout_nxt  = shreg;
            valid_nxt = 1'b1;
          end
          ferr_nxt = ~bus.sin;
`else
          if (bus.sin) begin
            dout_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      ferr_q  <= ferr_nxt;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= perr_nxt;
      pbad    <= pbad_nxt;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = ferr_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx
//   Directed bench for sipo_frame_rx (WIDTH=7, LSB first). Frame bit
//   vectors are written with the first transmitted bit in index 0.
//   Optional feature macro: SIPO_FRAME_RX_PARITY_EN
module tb_sipo_frame_rx;

  logic clk;
  logic res;
  int   n_checks;
  int   n_pass;

  sipo_frame_rx_if #(.WIDTH(7)) rx_bus ();

  sipo_frame_rx #(.WIDTH(7), .MSB_FIRST(1'b0)) dut (
    .clk (clk),
    .res (res),
    .bus (rx_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap, input bit spur);
    for (int g = 0; g < gap; g++) begin
      rx_bus.bit_en = 1'b0;
      rx_bus.sin    = 1'bx;
      rx_bus.start  = spur && (g == 0);
      tick();
      chk("gap_busy", 16'(rx_bus.busy), 16'h1);
    end
    rx_bus.start  = 1'b0;
    rx_bus.bit_en = 1'b1;
    rx_bus.sin    = b;
    tick();
    rx_bus.bit_en = 1'b0;
    rx_bus.sin    = 1'bx;
    chk("bit_busy", 16'(rx_bus.busy), 16'h1);
    chk("bit_novalid", 16'(rx_bus.dout_valid), 16'h0);
  endtask

  task automatic start_frame();
    rx_bus.start  = 1'b1;
    rx_bus.bit_en = 1'b1;   // must be ignored in the start cycle
    rx_bus.sin    = 1'b0;
    tick();
    rx_bus.start  = 1'b0;
    rx_bus.bit_en = 1'b0;
    chk("start_busy", 16'(rx_bus.busy), 16'h1);
  endtask

  task automatic send_data(input logic [6:0] bits, input bit gapped);
    int gaps [7];
    gaps = '{0, 3, 1, 2, 0, 3, 1};
    for (int i = 0; i < 7; i++)
      send_bit(bits[i], gapped ? gaps[i] : 0, gapped && (i == 3));
  endtask

  task automatic send_stop(input logic s, input logic st);
    rx_bus.bit_en = 1'b1;
    rx_bus.sin    = s;
    rx_bus.start  = st;
    tick();
    rx_bus.bit_en = 1'b0;
    rx_bus.start  = 1'b0;
    rx_bus.sin    = 1'bx;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    res = 1'b1;
    rx_bus.start  = 1'b0;
    rx_bus.bit_en = 1'b0;
    rx_bus.sin    = 1'b0;
    #2 res = 1'b0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 8; i++) begin
      rx_bus.start  = 1'($urandom);
      rx_bus.bit_en = 1'($urandom);
      rx_bus.sin    = 1'($urandom);
      tick();
      chk("rst_dout", 16'(rx_bus.dout), 16'h00);
      chk("rst_valid", 16'(rx_bus.dout_valid), 16'h0);
      chk("rst_busy", 16'(rx_bus.busy), 16'h0);
      chk("rst_ferr", 16'(rx_bus.frame_err), 16'h0);
`ifdef SIPO_FRAME_RX_PARITY_EN
      chk("rst_perr", 16'(rx_bus.parity_err), 16'h0);
`endif
    end
    rx_bus.start  = 1'b0;
    rx_bus.bit_en = 1'b0;
    res = 1'b1;
    tick();
    chk("idle_busy", 16'(rx_bus.busy), 16'h0);

    // Nominal frame 1,1,1,0,0,0,0 stop 1 -> 7'b0000111.
    start_frame();
    send_data(7'b0000111, 1'b0);
`ifdef SIPO_FRAME_RX_PARITY_EN
    send_bit(1'b1, 0, 1'b0);
`endif
    send_stop(1'b1, 1'b0);
    chk("nom_dout", 16'(rx_bus.dout), 16'h07);
    chk("nom_valid", 16'(rx_bus.dout_valid), 16'h1);
    chk("nom_busy_fall", 16'(rx_bus.busy), 16'h0);
    chk("nom_ferr", 16'(rx_bus.frame_err), 16'h0);
    tick();
    chk("nom_valid_once", 16'(rx_bus.dout_valid), 16'h0);
    chk("nom_dout_hold", 16'(rx_bus.dout), 16'h07);

    // Stop error: 1,0,1,0,1,0,1 stop 0; start held on the stop edge
    // must not open a new frame because the state is still STOP.
    start_frame();
    send_data(7'b1010101, 1'b0);
`ifdef SIPO_FRAME_RX_PARITY_EN
    send_bit(1'b0, 0, 1'b0);
`endif
    send_stop(1'b0, 1'b1);
    chk("serr_ferr", 16'(rx_bus.frame_err), 16'h1);
    chk("serr_valid", 16'(rx_bus.dout_valid), 16'h0);
    chk("serr_dout", 16'(rx_bus.dout), 16'h07);
    chk("serr_busy", 16'(rx_bus.busy), 16'h0);
    tick();
    chk("serr_ferr_once", 16'(rx_bus.frame_err), 16'h0);
    chk("serr_no_restart", 16'(rx_bus.busy), 16'h0);

    // Gapped strobes, spurious start mid-frame, stop 1 -> 7'b1010101.
    start_frame();
    send_data(7'b1010101, 1'b1);
`ifdef SIPO_FRAME_RX_PARITY_EN
    send_bit(1'b0, 2, 1'b0);
`endif
    send_stop(1'b1, 1'b0);
    chk("gap_dout", 16'(rx_bus.dout), 16'h55);
    chk("gap_valid", 16'(rx_bus.dout_valid), 16'h1);
    chk("gap_ferr", 16'(rx_bus.frame_err), 16'h0);
    tick();
    chk("gap_valid_once", 16'(rx_bus.dout_valid), 16'h0);

    // Reset after 3 data bits, between clock edges.
    start_frame();
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    #2 res = 1'b0;
    #1;
    chk("mid_rst_dout", 16'(rx_bus.dout), 16'h00);
    chk("mid_rst_busy", 16'(rx_bus.busy), 16'h0);
    chk("mid_rst_valid", 16'(rx_bus.dout_valid), 16'h0);
    tick();
    res = 1'b1;
    tick();
    chk("mid_rst_idle", 16'(rx_bus.busy), 16'h0);
    start_frame();
    send_data(7'b0110011, 1'b0);
`ifdef SIPO_FRAME_RX_PARITY_EN
    send_bit(1'b0, 0, 1'b0);
`endif
    send_stop(1'b1, 1'b0);
    chk("post_rst_dout", 16'(rx_bus.dout), 16'h33);
    chk("post_rst_valid", 16'(rx_bus.dout_valid), 16'h1);
    tick();

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Good parity: three ones in data, parity bit 1.
    start_frame();
    send_data(7'b0000111, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("par_ok_dout", 16'(rx_bus.dout), 16'h07);
    chk("par_ok_valid", 16'(rx_bus.dout_valid), 16'h1);
    chk("par_ok_perr", 16'(rx_bus.parity_err), 16'h0);
    tick();
    // Bad parity with good stop.
    start_frame();
    send_data(7'b0000111, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("par_bad_perr", 16'(rx_bus.parity_err), 16'h1);
    chk("par_bad_valid", 16'(rx_bus.dout_valid), 16'h0);
    chk("par_bad_dout", 16'(rx_bus.dout), 16'h07);
    chk("par_bad_ferr", 16'(rx_bus.frame_err), 16'h0);
    tick();
    chk("par_bad_once", 16'(rx_bus.parity_err), 16'h0);
    // Bad parity and bad stop: both pulses.
    start_frame();
    send_data(7'b0000111, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_stop(1'b0, 1'b0);
    chk("par_both_perr", 16'(rx_bus.parity_err), 16'h1);
    chk("par_both_ferr", 16'(rx_bus.frame_err), 16'h1);
    chk("par_both_valid", 16'(rx_bus.dout_valid), 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
